pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Hazard and sequencing controller for the 5-stage RISC-V pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  Produces forwarding selects, stall/flush enables and the data-memory request handshake.
//  Holds the pipeline through multi-cycle data-memory accesses and enters a sticky error state on memory timeout.
//  Keeps saturating stall and flush event counters for debug.
// PARAMETERS
//  MEM_TIMEOUT  16  max MEM_WAIT cycles before ERROR (>=2)
//  CNT_W        16  width of event counters
// PORTS
//  clk            in   1      clock, all state on rising edge
//  rst            in   1      synchronous, active-high reset
//  rs1_d, rs2_d   in   5      source regs in ID
//  rs1_e, rs2_e   in   5      source regs in EX
//  rd_e           in   5      dest reg in EX
//  rd_m           in   5      dest reg in MEM
//  rd_w           in   5      dest reg in WB
//  load_e         in   1      EX instruction is a load
//  reg_write_m    in   1      MEM instruction writes rd_m
//  reg_write_w    in   1      WB instruction writes rd_w
//  pc_src_e       in   1      branch/jump taken in EX
//  mem_access_m   in   1      MEM instruction is load or store
//  dmem_ready     in   1      data memory completes current request
//  forward_a_e    out  2      00 regfile, 01 WB result, 10 MEM alu_result
//  forward_b_e    out  2      as forward_a_e, for rs2
//  stall_f        out  1      hold PC
//  stall_d        out  1      hold IF/ID
//  stall_e        out  1      hold ID/EX
//  stall_m        out  1      hold EX/MEM
//  flush_d        out  1      clear IF/ID
//  flush_e        out  1      clear ID/EX
//  flush_w        out  1      clear MEM/WB (bubble)
//  dmem_req       out  1      data memory request
//  err            out  1      memory timeout, sticky
//  stall_cnt      out  CNT_W  cycles with stall_f high, saturating
//  flush_cnt      out  CNT_W  cycles with pc_src_e flush applied, saturating
// BEHAVIOUR
//  Reset:
//   - State RUN; timeout counter, stall_cnt, flush_cnt and err are 0.
//   - While rst is high: all stall_* = 0, flush_d = flush_e = flush_w = 1, dmem_req = 0.
//  Forwarding (combinational, all states):
//   - forward_a_e = 10 if reg_write_m & rd_m != 0 & rd_m == rs1_e.
//   - Otherwise forward_a_e = 01 if reg_write_w & rd_w != 0 & rd_w == rs1_e.
//   - Otherwise forward_a_e = 00. MEM has priority over WB. forward_b_e is the same rule on rs2_e.
//  Signals:
//   - lw_hz   = load_e & rd_e != 0 & (rd_e == rs1_d | rd_e == rs2_d)
//   - mem_hold = (state == RUN & mem_access_m & !dmem_ready) | state == MEM_WAIT & !dmem_ready
//  dmem_req:
//   - Equals mem_access_m in RUN and in MEM_WAIT; 0 in ERROR.
//   - The request is held stable until dmem_ready is seen.
//  States:
//   - RUN -> MEM_WAIT when mem_access_m & !dmem_ready.
//   - RUN with ready in the same cycle is a zero-wait access with no stall.
//   - MEM_WAIT -> RUN on dmem_ready. In that cycle no stall, and the pipeline advances.
//   - MEM_WAIT -> ERROR when the timeout counter reaches MEM_TIMEOUT-1 without ready.
//   - The timeout counter clears on entering MEM_WAIT and increments each MEM_WAIT cycle.
//   - ERROR is left only by rst.
//  Outputs by condition:
//   - mem_hold: stall_f = stall_d = stall_e = stall_m = 1 and flush_w = 1. flush_d = flush_e = 0.
//   - mem_hold: lw_hz and pc_src_e are ignored; they are re-evaluated when released.
//   - ERROR: all stall_* = 1, flush_w = 1, err = 1.
//   - Otherwise, pc_src_e: flush_d = flush_e = 1 and stall_f = stall_d = 0. The branch wins over lw_hz.
//   - Otherwise, lw_hz: stall_f = stall_d = 1 and flush_e = 1.
//   - Otherwise: all 0.
//  Counters:
//   - stall_cnt increments each cycle stall_f = 1; flush_cnt increments each cycle a pc_src_e flush is applied.
//   - Both saturate at 2^CNT_W - 1 with no wrap.
// TESTING
//  1. rd_m = 5, reg_write_m = 1, rd_w = 5, reg_write_w = 1, rs1_e = 5 -> forward_a_e = 10. With rd_m = 0 -> 01. With rs1_e = 0 -> 00.
//  2. load_e = 1, rd_e = 7, rs2_d = 7 -> one cycle of stall_f = stall_d = flush_e = 1; stall_cnt = 1.
//  3. lw_hz and pc_src_e in the same cycle -> flush_d = flush_e = 1, stall_f = 0; flush_cnt = 1.
//  4. mem_access_m = 1, dmem_ready low 3 cycles then high -> 3 cycles of all stall_* = 1, flush_w = 1, then all 0 and state RUN.
//  5. MEM_TIMEOUT = 4, dmem_ready never asserted -> err = 1 after 4 MEM_WAIT cycles, dmem_req = 0, stalls held; rst -> err = 0, counters = 0.
//  6. CNT_W = 3, hold a load-use stall for 10 cycles -> stall_cnt stays at 7; rst mid-MEM_WAIT -> state RUN next cycle.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for a 5-stage RISC-V pipeline: forwarding selects,
// stall/flush control, data-memory handshake with timeout, and saturating debug counters.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [4:0]       i_rs1_d,
  input  logic [4:0]       i_rs2_d,
  input  logic [4:0]       i_rs1_e,
  input  logic [4:0]       i_rs2_e,
  input  logic [4:0]       i_rd_e,
  input  logic [4:0]       i_rd_m,
  input  logic [4:0]       i_rd_w,
  input  logic             i_load_e,
  input  logic             i_reg_write_m,
  input  logic             i_reg_write_w,
  input  logic             i_pc_src_e,
  input  logic             i_mem_access_m,
  input  logic             i_dmem_ready,
  output logic [1:0]       o_forward_a_e,
  output logic [1:0]       o_forward_b_e,
  output logic             o_stall_f,
  output logic             o_stall_d,
  output logic             o_stall_e,
  output logic             o_stall_m,
  output logic             o_flush_d,
  output logic             o_flush_e,
  output logic             o_flush_w,
  output logic             o_dmem_req,
  output logic             o_err,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  localparam int TW = $clog2(MEM_TIMEOUT);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

  state_t           r_state;
  logic [TW-1:0]    r_timeoutCnt;
  logic [CNT_W-1:0] r_stallCnt;
  logic [CNT_W-1:0] r_flushCnt;

  logic w_lwHz;
  logic w_memHold;
  logic w_branchFlush;

  // MEM result is younger than WB, so it takes priority when both match.
  always_comb begin
    o_forward_a_e = 2'b00;
    o_forward_b_e = 2'b00;
    if (i_reg_write_m && i_rd_m != 5'd0 && i_rd_m == i_rs1_e)
      o_forward_a_e = 2'b10;
    else if (i_reg_write_w && i_rd_w != 5'd0 && i_rd_w == i_rs1_e)
      o_forward_a_e = 2'b01;
    if (i_reg_write_m && i_rd_m != 5'd0 && i_rd_m == i_rs2_e)
      o_forward_b_e = 2'b10;
    else if (i_reg_write_w && i_rd_w != 5'd0 && i_rd_w == i_rs2_e)
      o_forward_b_e = 2'b01;
  end

  assign w_lwHz = i_load_e && i_rd_e != 5'd0 && (i_rd_e == i_rs1_d || i_rd_e == i_rs2_d);
  assign w_memHold = ((r_state == RUN) && i_mem_access_m && !i_dmem_ready) ||
                     ((r_state == MEM_WAIT) && !i_dmem_ready);
  assign w_branchFlush = !i_rst && (r_state != ERROR) && !w_memHold && i_pc_src_e;

  // A memory hold freezes everything, so branch and load-use are only acted on once released.
  always_comb begin
    o_stall_f  = 1'b0;
    o_stall_d  = 1'b0;
    o_stall_e  = 1'b0;
    o_stall_m  = 1'b0;
    o_flush_d  = 1'b0;
    o_flush_e  = 1'b0;
    o_flush_w  = 1'b0;
    o_dmem_req = 1'b0;
    if (i_rst) begin
      o_flush_d = 1'b1;
      o_flush_e = 1'b1;
      o_flush_w = 1'b1;
    end else if (r_state == ERROR) begin
      {o_stall_f, o_stall_d, o_stall_e, o_stall_m} = 4'b1111;
      o_flush_w = 1'b1;
    end else if (w_memHold) begin
      {o_stall_f, o_stall_d, o_stall_e, o_stall_m} = 4'b1111;
      o_flush_w  = 1'b1;
      o_dmem_req = i_mem_access_m;
    end else begin
      o_dmem_req = i_mem_access_m;
      if (i_pc_src_e) begin
        o_flush_d = 1'b1;
        o_flush_e = 1'b1;
      end else if (w_lwHz) begin
        o_stall_f = 1'b1;
        o_stall_d = 1'b1;
        o_flush_e = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= RUN;
      r_timeoutCnt <= '0;
      r_stallCnt   <= '0;
      r_flushCnt   <= '0;
    end else begin
      if (o_stall_f && r_stallCnt != '1)
        r_stallCnt <= r_stallCnt + 1'b1;
      if (w_branchFlush && r_flushCnt != '1)
        r_flushCnt <= r_flushCnt + 1'b1;
      case (r_state)
        RUN: begin
          if (i_mem_access_m && !i_dmem_ready) begin
            r_state      <= MEM_WAIT;
            r_timeoutCnt <= '0;
          end
        end
        MEM_WAIT: begin
          if (i_dmem_ready)
            r_state <= RUN;
          else if (r_timeoutCnt == TW'(MEM_TIMEOUT - 1))
            r_state <= ERROR;
          else
            r_timeoutCnt <= r_timeoutCnt + 1'b1;
        end
        ERROR:   r_state <= ERROR;
        default: r_state <= RUN;
      endcase
    end
  end

  assign o_err       = (r_state == ERROR);
  assign o_stall_cnt = r_stallCnt;
  assign o_flush_cnt = r_flushCnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a cycle-level reference model of the controller rules.
module tb_pipe_hazard_ctrl;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 3;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic       loadE, regWriteM, regWriteW, pcSrcE, memAccessM, dmemReady;

  logic [1:0]       fwdA, fwdB;
  logic             stallF, stallD, stallE, stallM;
  logic             flushD, flushE, flushW;
  logic             dmemReq, err;
  logic [CNT_W-1:0] stallCnt, flushCnt;

  int compareCount = 0;
  int failCount    = 0;

  // Reference model: how long we have been waiting on memory, whether we timed out, event tallies.
  bit mErr       = 1'b0;
  bit mWaiting   = 1'b0;
  int mWaitCnt   = 0;
  int mStallCnt  = 0;
  int mFlushCnt  = 0;
  bit lastStallF = 1'b0;
  bit lastBranch = 1'b0;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_rs1_d(rs1D), .i_rs2_d(rs2D), .i_rs1_e(rs1E), .i_rs2_e(rs2E),
    .i_rd_e(rdE), .i_rd_m(rdM), .i_rd_w(rdW),
    .i_load_e(loadE), .i_reg_write_m(regWriteM), .i_reg_write_w(regWriteW),
    .i_pc_src_e(pcSrcE), .i_mem_access_m(memAccessM), .i_dmem_ready(dmemReady),
    .o_forward_a_e(fwdA), .o_forward_b_e(fwdB),
    .o_stall_f(stallF), .o_stall_d(stallD), .o_stall_e(stallE), .o_stall_m(stallM),
    .o_flush_d(flushD), .o_flush_e(flushE), .o_flush_w(flushW),
    .o_dmem_req(dmemReq), .o_err(err),
    .o_stall_cnt(stallCnt), .o_flush_cnt(flushCnt)
  );

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compareCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] refForward(input logic [4:0] rs);
    if (regWriteM && rdM != 0 && rdM == rs) return 2'b10;
    if (regWriteW && rdW != 0 && rdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic clearInputs();
    rst = 0; rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0; rdE = 0; rdM = 0; rdW = 0;
    loadE = 0; regWriteM = 0; regWriteW = 0; pcSrcE = 0; memAccessM = 0; dmemReady = 0;
  endtask

  task automatic applyStimulus();
    rst        = ($urandom_range(0, 49) == 0);
    rs1D       = 5'($urandom_range(0, 3));
    rs2D       = 5'($urandom_range(0, 3));
    rs1E       = 5'($urandom_range(0, 3));
    rs2E       = 5'($urandom_range(0, 3));
    rdE        = 5'($urandom_range(0, 3));
    rdM        = 5'($urandom_range(0, 3));
    rdW        = 5'($urandom_range(0, 3));
    loadE      = 1'($urandom);
    regWriteM  = 1'($urandom);
    regWriteW  = 1'($urandom);
    pcSrcE     = ($urandom_range(0, 3) == 0);
    memAccessM = ($urandom_range(0, 2) == 0);
    dmemReady  = 1'($urandom);
  endtask

  task automatic checkOutput();
    logic [3:0] expStall;
    logic [2:0] expFlush;
    logic       expReq;
    bit         hold, lwHz;
    lwHz = loadE && rdE != 0 && (rdE == rs1D || rdE == rs2D);
    hold = !mErr && !dmemReady && (mWaiting || memAccessM);
    expStall = 4'b0000;
    expFlush = 3'b000;
    expReq   = 1'b0;
    if (rst) begin
      expFlush = 3'b111;
    end else if (mErr) begin
      expStall = 4'b1111;
      expFlush = 3'b001;
    end else if (hold) begin
      expStall = 4'b1111;
      expFlush = 3'b001;
      expReq   = memAccessM;
    end else begin
      expReq = memAccessM;
      if (pcSrcE) expFlush = 3'b110;
      else if (lwHz) begin
        expStall = 4'b1100;
        expFlush = 3'b010;
      end
    end
    lastStallF = expStall[3];
    lastBranch = !rst && !mErr && !hold && pcSrcE;
    checkValue("fwdA",     32'(fwdA), 32'(refForward(rs1E)));
    checkValue("fwdB",     32'(fwdB), 32'(refForward(rs2E)));
    checkValue("stall",    32'({stallF, stallD, stallE, stallM}), 32'(expStall));
    checkValue("flush",    32'({flushD, flushE, flushW}), 32'(expFlush));
    checkValue("dmemReq",  32'(dmemReq), 32'(expReq));
    checkValue("err",      32'(err), 32'(mErr));
    checkValue("stallCnt", 32'(stallCnt), 32'(mStallCnt));
    checkValue("flushCnt", 32'(flushCnt), 32'(mFlushCnt));
  endtask

  task automatic updateModel();
    if (rst) begin
      mErr = 0; mWaiting = 0; mWaitCnt = 0; mStallCnt = 0; mFlushCnt = 0;
    end else begin
      if (lastStallF && mStallCnt < CNT_MAX) mStallCnt++;
      if (lastBranch && mFlushCnt < CNT_MAX) mFlushCnt++;
      if (!mErr) begin
        if (mWaiting) begin
          if (dmemReady) mWaiting = 0;
          else if (mWaitCnt == MEM_TIMEOUT - 1) begin
            mErr = 1;
            mWaiting = 0;
          end else mWaitCnt++;
        end else if (memAccessM && !dmemReady) begin
          mWaiting = 1;
          mWaitCnt = 0;
        end
      end
    end
  endtask

  task automatic stepCycle();
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    updateModel();
    #1;
  endtask

  task automatic resetCycle();
    clearInputs();
    rst = 1;
    stepCycle();
    rst = 0;
  endtask

  initial begin
    clearInputs();
    rst = 1;
    @(posedge clk);
    #1;
    resetCycle();

    $display("[TB] forwarding priority");
    rdM = 5; regWriteM = 1; rdW = 5; regWriteW = 1; rs1E = 5;
    stepCycle();
    checkValue("t1_fwdMem", 32'(fwdA), 32'(2'b10));
    rdM = 0;
    stepCycle();
    checkValue("t1_fwdWb", 32'(fwdA), 32'(2'b01));
    rs1E = 0;
    stepCycle();
    checkValue("t1_fwdNone", 32'(fwdA), 32'(2'b00));

    $display("[TB] load-use stall");
    resetCycle();
    loadE = 1; rdE = 7; rs2D = 7;
    stepCycle();
    loadE = 0;
    stepCycle();
    checkValue("t2_stallCnt", 32'(stallCnt), 32'd1);

    $display("[TB] branch beats load-use");
    resetCycle();
    loadE = 1; rdE = 7; rs2D = 7; pcSrcE = 1;
    stepCycle();
    checkValue("t3_stallF", 32'(stallF), 32'd0);
    checkValue("t3_flushD", 32'(flushD), 32'd1);
    clearInputs();
    stepCycle();
    checkValue("t3_flushCnt", 32'(flushCnt), 32'd1);

    $display("[TB] multi-cycle memory access");
    resetCycle();
    memAccessM = 1; dmemReady = 0;
    repeat (3) stepCycle();
    dmemReady = 1;
    stepCycle();
    checkValue("t4_releaseStall", 32'(stallM), 32'd0);
    memAccessM = 0; dmemReady = 0;
    stepCycle();
    checkValue("t4_stallCnt", 32'(stallCnt), 32'd3);

    $display("[TB] memory timeout");
    resetCycle();
    memAccessM = 1; dmemReady = 0;
    repeat (5) stepCycle();
    checkValue("t5_err", 32'(err), 32'd1);
    checkValue("t5_req", 32'(dmemReq), 32'd0);
    checkValue("t5_stallM", 32'(stallM), 32'd1);
    stepCycle();
    resetCycle();
    checkValue("t5_errCleared", 32'(err), 32'd0);
    checkValue("t5_stallCntCleared", 32'(stallCnt), 32'd0);

    $display("[TB] counter saturation and reset during wait");
    loadE = 1; rdE = 7; rs1D = 7;
    repeat (10) stepCycle();
    checkValue("t6_stallCntSat", 32'(stallCnt), 32'(CNT_MAX));
    clearInputs();
    memAccessM = 1;
    stepCycle();
    stepCycle();
    resetCycle();
    stepCycle();
    checkValue("t6_runAfterReset", 32'(stallF), 32'd0);

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      applyStimulus();
      stepCycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
